// File: rtl/serial_tx_if.sv
// Handshake and line signals between a word source and the serial transmitter.
// The master drives start/data; the transmitter (slave) drives the line and status.
interface serial_tx_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] data;
  logic             ready;
  logic             txd;
  logic             busy;
  logic             done;

  modport master (
    output start, data,
    input  ready, txd, busy, done
  );

  modport slave (
    input  start, data,
    output ready, txd, busy, done
  );
endinterface

// File: rtl/serial_tx.sv
// Serial frame transmitter: start bit (0), WIDTH data bits LSB first, stop bit (1),
// each bit held for DIV clocks. txd and done are registered from the next-state values.
module serial_tx #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic        clk,
  input  logic        reset,
  serial_tx_if.slave  bus
);

  localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   bitCnt_q, bitCnt_d;
  logic [IDX_W-1:0]   bitIdx_q, bitIdx_d;
  logic [WIDTH-1:0]   shift_q, shift_d;
  logic               txd_q, txd_d;
  logic               done_q, done_d;
  logic               bitEnd;

  assign bitEnd = (bitCnt_q == CNT_MAX);

  // txd/done are derived from the next state so the registered line changes
  // in the same cycle the state does, with no combinational path to outputs.
  always_comb begin
    state_d  = state_q;
    bitCnt_d = bitCnt_q;
    bitIdx_d = bitIdx_q;
    shift_d  = shift_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d  = START;
          shift_d  = bus.data;
          bitCnt_d = '0;
        end
      end
      START: begin
        if (bitEnd) begin
          bitCnt_d = '0;
          bitIdx_d = '0;
          state_d  = DATA;
        end else begin
          bitCnt_d = bitCnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (bitEnd) begin
          bitCnt_d = '0;
          if (bitIdx_q == IDX_MAX) begin
            state_d = STOP;
          end else begin
            shift_d  = shift_q >> 1;
            bitIdx_d = bitIdx_q + IDX_W'(1);
          end
        end else begin
          bitCnt_d = bitCnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (bitEnd) begin
          bitCnt_d = '0;
          state_d  = IDLE;
        end else begin
          bitCnt_d = bitCnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    case (state_d)
      START:   txd_d = 1'b0;
      DATA:    txd_d = shift_d[0];
      default: txd_d = 1'b1;
    endcase
    done_d = (state_d == STOP) && (bitCnt_d == CNT_MAX);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      bitCnt_q <= '0;
      bitIdx_q <= '0;
      shift_q  <= '0;
      txd_q    <= 1'b1;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitCnt_q <= bitCnt_d;
      bitIdx_q <= bitIdx_d;
      shift_q  <= shift_d;
      txd_q    <= txd_d;
      done_q   <= done_d;
    end
  end

  assign bus.txd   = txd_q;
  assign bus.done  = done_q;
  assign bus.ready = (state_q == IDLE);
  assign bus.busy  = (state_q != IDLE);

endmodule
